// File: rtl/apb_reg_slave.sv
`default_nettype none
// ============================================================================
//  Module      : apb_reg_slave
//  Description : APB slave register bank with programmable wait states.
//                NUM_REGS-1 read/write registers and a read-only count of
//                completed transfers in the top slot. Illegal accesses
//                (bad address, write to the counter) complete with PSLVERR.
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_reg_slave #(
    parameter int          NUM_REGS    = 8,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR
);

    localparam int         c_idx_w     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int         c_cnt_idx   = NUM_REGS - 1;
    localparam logic [3:0] c_wait_init = 4'(WAIT_STATES);
    localparam bit         c_zero_wait = (WAIT_STATES == 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [31:0] r_regs [0:NUM_REGS-2];
    logic [31:0] r_xfer_cnt;
    logic [31:0] r_paddr;
    logic [31:0] r_pwdata;
    logic        r_pwrite;
    logic [3:0]  r_wait;
    logic [31:0] r_prdata;
    logic        r_pready;
    logic        r_pslverr;

    logic               w_setup;
    logic               w_abort;
    logic               w_commit;
    logic               w_wait_step;
    logic [31:0]        w_dec_addr;
    logic               w_dec_write;
    logic [32:0]        w_offset;
    logic [c_idx_w-1:0] w_idx;
    logic               w_valid;
    logic               w_is_cnt;
    logic               w_err;
    logic [31:0]        w_rdata;

    assign PRDATA  = r_prdata;
    assign PREADY  = r_pready;
    assign PSLVERR = r_pslverr;

    // Transfer event strobes; a setup phase is accepted from IDLE or DONE.
    always_comb begin
        w_setup     = (r_state != ACCESS) && PSEL && !PENABLE;
        w_abort     = (r_state == ACCESS) && !PSEL;
        w_commit    = (r_state == ACCESS) && PSEL && PENABLE && r_pready;
        w_wait_step = (r_state == ACCESS) && PSEL && PENABLE && !r_pready;
    end

    // Address decode: the live bus at the setup edge (zero-wait response is
    // produced there), otherwise the latched transfer. 33-bit offset so an
    // address below BASE_ADDR shows up as a negative (bit 32 set).
    always_comb begin
        w_dec_addr  = w_setup ? PADDR  : r_paddr;
        w_dec_write = w_setup ? PWRITE : r_pwrite;
        w_offset    = {1'b0, w_dec_addr} - {1'b0, BASE_ADDR};
        w_valid     = !w_offset[32] && (w_offset[1:0] == 2'b00) &&
                      (w_offset[32:2] < 31'(NUM_REGS));
        w_idx       = w_offset[c_idx_w+1:2];
        w_is_cnt    = (w_idx == c_idx_w'(c_cnt_idx));
        w_err       = !w_valid || (w_dec_write && w_is_cnt);
        w_rdata     = r_xfer_cnt;
        if (w_valid && !w_is_cnt) begin
            w_rdata = r_regs[w_idx];
        end
    end

    // FSM state register.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state; PSEL+PENABLE seen in IDLE is a protocol violation and ignored.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (PSEL && !PENABLE) w_state_nxt = ACCESS;
            end
            ACCESS: begin
                if (!PSEL)                   w_state_nxt = IDLE;
                else if (PENABLE && r_pready) w_state_nxt = DONE;
            end
            DONE: begin
                if (PSEL && !PENABLE) w_state_nxt = ACCESS;
                else                  w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath: latch request, count wait states, raise response, commit.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            for (int i = 0; i < NUM_REGS - 1; i++) begin
                r_regs[i] <= '0;
            end
            r_xfer_cnt <= '0;
            r_paddr    <= '0;
            r_pwdata   <= '0;
            r_pwrite   <= 1'b0;
            r_wait     <= '0;
            r_prdata   <= '0;
            r_pready   <= 1'b0;
            r_pslverr  <= 1'b0;
        end else if (w_setup) begin
            r_paddr  <= PADDR;
            r_pwdata <= PWDATA;
            r_pwrite <= PWRITE;
            r_wait   <= c_wait_init;
            r_pready <= c_zero_wait;
            if (c_zero_wait) begin
                r_pslverr <= w_err;
                if (!w_dec_write) r_prdata <= w_err ? 32'h0 : w_rdata;
            end else begin
                r_pslverr <= 1'b0;
            end
        end else if (w_abort) begin
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
        end else if (w_commit) begin
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            if (!r_pslverr) begin
                r_xfer_cnt <= r_xfer_cnt + 32'd1;
                if (r_pwrite) r_regs[w_idx] <= r_pwdata;
            end
        end else if (w_wait_step) begin
            r_wait <= r_wait - 4'd1;
            if (r_wait == 4'd1) begin
                r_pready  <= 1'b1;
                r_pslverr <= w_err;
                if (!w_dec_write) r_prdata <= w_err ? 32'h0 : w_rdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apb_reg_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_reg_slave
//  Description : Self-checking bench for apb_reg_slave. Three instances with
//                WAIT_STATES = 1, 0 and 3 share one APB bus (separate PSEL).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_reg_slave;

    localparam int          c_nregs = 8;
    localparam logic [31:0] c_base  = 32'h0000_0000;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic [2:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata  [3];
    logic        pready  [3];
    logic        pslverr [3];

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_regs [3][c_nregs];
    logic [31:0] m_cnt  [3];

    always #5 PCLK = ~PCLK;

    apb_reg_slave #(.NUM_REGS(c_nregs), .WAIT_STATES(1), .BASE_ADDR(c_base)) dut0 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));
    apb_reg_slave #(.NUM_REGS(c_nregs), .WAIT_STATES(0), .BASE_ADDR(c_base)) dut1 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));
    apb_reg_slave #(.NUM_REGS(c_nregs), .WAIT_STATES(3), .BASE_ADDR(c_base)) dut2 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[2]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]));

    function automatic int ws(input int d);
        case (d)
            0:       return 1;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_cnt[d] = 32'h0;
            for (int i = 0; i < c_nregs; i++) m_regs[d][i] = 32'h0;
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        for (int d = 0; d < 3; d++) begin
            chk({tag, "_prdata"},  prdata[d],  32'h0);
            chk({tag, "_pready"},  32'(pready[d]),  32'h0);
            chk({tag, "_pslverr"}, 32'(pslverr[d]), 32'h0);
        end
    endtask

    // One complete transfer on instance d; returns in the PREADY=1 cycle with
    // PSEL/PENABLE still high, so a following call is a back-to-back setup.
    task automatic xfer(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd);
        longint      off;
        longint      idx;
        bit          err;
        logic [31:0] exp_rd;
        int          waits;
        bit          got;
        off    = longint'(a) - longint'(c_base);
        idx    = off / 4;
        err    = (off < 0) || (a[1:0] != 2'b00) || (idx >= c_nregs) ||
                 (wr && idx == c_nregs - 1);
        exp_rd = 32'h0;
        if (!err) exp_rd = (idx == c_nregs - 1) ? m_cnt[d] : m_regs[d][idx];

        @(negedge PCLK);
        chk("ready_low_before_setup", 32'(pready[d]), 32'h0);
        psel    = 3'b000;
        psel[d] = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = a;
        pwdata  = wd;
        @(negedge PCLK);
        penable = 1'b1;
        waits = 0;
        got   = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            if (pready[d] === 1'b1) got = 1'b1;
            else begin
                waits++;
                @(negedge PCLK);
            end
        end
        if (!got) begin
            chk("pready_timeout", 32'h0, 32'h1);
            return;
        end
        chk("wait_cycles", 32'(waits), 32'(ws(d)));
        chk("pslverr", 32'(pslverr[d]), 32'(err));
        if (!wr) chk("prdata", prdata[d], exp_rd);
        if (!err) begin
            m_cnt[d] = m_cnt[d] + 32'd1;
            if (wr) m_regs[d][idx] = wd;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge PCLK);
            psel    = 3'b000;
            penable = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] ra;
        PRESET  = 1'b1;
        psel    = 3'b000;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 32'h0;
        pwdata  = 32'h0;
        model_reset();
        repeat (2) @(negedge PCLK);
        chk_outputs_zero("reset");
        PRESET = 1'b0;

        // Read every slot after reset; the counter slot shows prior reads.
        for (int i = 0; i < c_nregs; i++) begin
            xfer(0, 1'b0, 32'(i * 4), 32'h0);
            idle(1);
        end

        // Write and read back with one wait state.
        xfer(0, 1'b1, 32'h08, 32'hDEAD_BEEF);
        idle(1);
        xfer(0, 1'b0, 32'h08, 32'h0);
        idle(1);

        // Error cases: counter write, out of range, unaligned.
        xfer(0, 1'b1, 32'h1C, 32'h1111_1111);
        idle(1);
        xfer(0, 1'b1, 32'h20, 32'h2222_2222);
        idle(1);
        xfer(0, 1'b1, 32'h05, 32'h3333_3333);
        idle(1);
        xfer(0, 1'b0, 32'h20, 32'h0);
        idle(1);
        xfer(0, 1'b0, 32'hFFFF_FFFC, 32'h0);
        idle(1);
        xfer(0, 1'b0, 32'h1C, 32'h0);
        idle(1);
        xfer(0, 1'b0, 32'h08, 32'h0);
        idle(1);

        // Zero wait states, back-to-back write then read (setup in DONE).
        xfer(1, 1'b1, 32'h04, 32'hCAFE_F00D);
        xfer(1, 1'b0, 32'h04, 32'h0);
        xfer(1, 1'b0, 32'h1C, 32'h0);
        idle(1);

        // Abort a write on the three-wait instance in its second wait cycle.
        xfer(2, 1'b1, 32'h00, 32'h5A5A_0001);
        idle(1);
        @(negedge PCLK);
        psel    = 3'b100;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 32'h00;
        pwdata  = 32'hBAD0_BAD0;
        @(negedge PCLK);
        penable = 1'b1;
        chk("abort_wait1_pready", 32'(pready[2]), 32'h0);
        @(negedge PCLK);
        chk("abort_wait2_pready", 32'(pready[2]), 32'h0);
        psel    = 3'b000;
        penable = 1'b0;
        @(negedge PCLK);
        chk("abort_after_pready", 32'(pready[2]), 32'h0);
        xfer(2, 1'b0, 32'h00, 32'h0);
        idle(1);
        xfer(2, 1'b0, 32'h1C, 32'h0);
        idle(1);

        // Protocol violation in IDLE: PSEL with PENABLE and no setup.
        @(negedge PCLK);
        psel    = 3'b010;
        penable = 1'b1;
        pwrite  = 1'b1;
        paddr   = 32'h10;
        pwdata  = 32'hFFFF_0000;
        repeat (3) begin
            @(negedge PCLK);
            chk("violation_pready", 32'(pready[1]), 32'h0);
        end
        idle(1);
        xfer(1, 1'b0, 32'h10, 32'h0);
        idle(1);

        // Randomized traffic against the reference model.
        for (int t = 0; t < 60; t++) begin
            case ($urandom_range(0, 9))
                0:       ra = 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(1, 3));
                1:       ra = 32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3));
                default: ra = 32'(4 * $urandom_range(0, 9));
            endcase
            xfer(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), ra, $urandom);
            if ($urandom_range(0, 1) == 1) idle(1);
        end
        idle(1);

        // Counter wrap from all-ones to zero.
        @(negedge PCLK);
        force dut0.r_xfer_cnt = 32'hFFFF_FFFF;
        #1;
        release dut0.r_xfer_cnt;
        m_cnt[0] = 32'hFFFF_FFFF;
        xfer(0, 1'b0, 32'h1C, 32'h0);
        idle(1);
        xfer(0, 1'b0, 32'h1C, 32'h0);
        idle(1);

        // Asynchronous reset while PREADY=1 with nonzero read data.
        xfer(0, 1'b1, 32'h0C, 32'h1234_5678);
        idle(1);
        @(negedge PCLK);
        psel    = 3'b001;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 32'h0C;
        @(negedge PCLK);
        penable = 1'b1;
        @(negedge PCLK);
        chk("prereset_pready", 32'(pready[0]), 32'h1);
        chk("prereset_prdata", prdata[0], 32'h1234_5678);
        #2;
        PRESET = 1'b1;
        #1;
        chk_outputs_zero("async_reset");
        psel    = 3'b000;
        penable = 1'b0;
        @(negedge PCLK);
        PRESET = 1'b0;
        model_reset();
        xfer(0, 1'b0, 32'h0C, 32'h0);
        idle(1);
        xfer(0, 1'b0, 32'h1C, 32'h0);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
